branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Resolution end of the 2-bit dynamic prediction path. Queues each conditional-branch
//  prediction issued in ID, then retires it when EX resolves that branch.
//  On retirement: detects mispredicts, supplies the correction PC, emits the saturating-counter
//  write-back for the pattern table, and keeps branch/mispredict statistics.
//  Sits between the ID-stage predictor lookup and the EX-stage branch comparator.
// PARAMETERS
//  DEPTH  4   pending-prediction queue entries (power of 2, >=2)
//  IDX_W  13  pattern-table index width (PC[14:2])
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous active-high reset
//  stall          in   1      pipeline stall; no push/pop while high
//  exc_flush      in   1      exception flush; discards all pending predictions
//  id_push        in   1      conditional branch in ID with prediction made
//  id_pred_taken  in   1      predicted direction
//  id_pred_ctr    in   2      2-bit counter value read at prediction time
//  id_idx         in   IDX_W  pattern-table index of the branch
//  id_alt_pc      in   32     PC to fetch if prediction wrong (target or PC+4)
//  ex_resolve     in   1      conditional branch resolved in EX this cycle
//  ex_taken       in   1      actual direction
//  full           out  1      queue full; ID must stall further branches
//  mispredict     out  1      one-cycle pulse: retired branch mispredicted
//  correct_pc     out  32     valid with mispredict; alt PC of retired entry
//  upd_en         out  1      one-cycle pulse: write upd_ctr at upd_idx
//  upd_idx        out  IDX_W  table index to update
//  upd_ctr        out  2      new counter value
//  underflow      out  1      sticky error: resolve with empty queue or push while full
//  br_count       out  32     retired conditional branches
//  miss_count     out  32     retired mispredicts
// BEHAVIOUR
//  Reset: queue empty; all outputs 0, including counters and underflow.
//  Queue:
//   - push = id_push & ~stall; pop = ex_resolve & ~stall & ~empty.
//   - FIFO order; read/write pointers wrap modulo DEPTH.
//   - full = (count == DEPTH), combinational from count.
//   - Push while full with no pop: dropped; sets underflow.
//   - Push and pop in the same cycle while full: both accepted; count unchanged.
//   - ex_resolve & ~stall while empty: no pop; sets underflow.
//  Retire, for the popped head entry:
//   - miss = ex_taken ^ pred_taken.
//   - Next cycle: upd_en=1, upd_idx=idx, mispredict=miss, correct_pc=alt_pc.
//   - Latency from pop to these outputs is exactly 1 cycle.
//   - Outputs are pulses; they do not hold during stall.
//   - upd_ctr: taken -> min(ctr+1,3); not taken -> max(ctr-1,0).
//  Mispredict squash:
//   - In the pop cycle where miss=1, every younger entry is wrong-path.
//   - The queue is cleared and any simultaneous push is discarded.
//  Counters:
//   - br_count +1 per pop; miss_count +1 per missed pop.
//   - 32-bit wrap; not cleared by exc_flush.
//  exc_flush (when rst is low):
//   - Clears queue and pointers; cancels that cycle's push/pop.
//   - Output pulses are 0 on the following cycle.
//   - Takes priority over stall.
//  rst has priority over everything.
// TESTING
//  1. Push (taken, ctr=2, idx=5, alt=0x100), then resolve taken
//     -> next cycle upd_en=1, upd_idx=5, upd_ctr=3, mispredict=0, br_count=1.
//  2. Push (taken, ctr=3, alt=0x2004), younger push, then resolve not-taken
//     -> mispredict=1, correct_pc=0x2004, upd_ctr=2, queue empty, miss_count=1.
//  3. Push DEPTH entries -> full=1; push plus resolve in the same cycle
//     -> count stays DEPTH, no underflow; a further lone push sets underflow=1.
//  4. Saturation: ctr=0 resolved not-taken -> upd_ctr=0; ctr=3 resolved taken -> upd_ctr=3.
//  5. stall=1 with id_push and ex_resolve -> no state change, no pulses.
//     exc_flush with 3 entries -> empty; next resolve sets underflow.
//  6. rst asserted mid-stream -> queue empty; counters, underflow and all pulses 0 next cycle.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Retire side of the 2-bit dynamic branch predictor. Each conditional-branch
//   prediction made in ID is queued in order. When EX resolves the oldest branch,
//   this block flags a mispredict, supplies the correction PC, and emits the
//   saturating-counter write-back for the pattern table. It also keeps
//   retired-branch and mispredict statistics.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   stall, exc_flush     pipeline stall / exception flush (flush wins)
//   id_*                 prediction push from ID (dir, counter, index, alt PC)
//   ex_resolve, ex_taken branch resolution from EX
//   full                 queue full (combinational from occupancy)
//   mispredict, correct_pc, upd_en, upd_idx, upd_ctr
//                        one-cycle retire pulses, registered one cycle after pop
//   underflow            sticky: resolve with empty queue or push into full queue
//   br_count, miss_count 32-bit wrapping statistics
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_flush,
  input  logic             id_push,
  input  logic             id_pred_taken,
  input  logic [1:0]       id_pred_ctr,
  input  logic [IDX_W-1:0] id_idx,
  input  logic [31:0]      id_alt_pc,
  input  logic             ex_resolve,
  input  logic             ex_taken,
  output logic             full,
  output logic             mispredict,
  output logic [31:0]      correct_pc,
  output logic             upd_en,
  output logic [IDX_W-1:0] upd_idx,
  output logic [1:0]       upd_ctr,
  output logic             underflow,
  output logic [31:0]      br_count,
  output logic [31:0]      miss_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic             taken;
    logic [1:0]       ctr;
    logic [IDX_W-1:0] idx;
    logic [31:0]      alt_pc;
  } entry_t;

  entry_t        q [DEPTH];
  entry_t        head;
  entry_t        wr_ent;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;

  logic empty, push_req, res_req, pop, miss, push_ok, ovf, res_empty;
  logic [1:0] nxt_ctr;

  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign head   = q[rd_ptr];
  assign wr_ent = '{taken: id_pred_taken, ctr: id_pred_ctr, idx: id_idx, alt_pc: id_alt_pc};

  // Flush cancels the cycle's push/pop outright, ahead of stall.
  assign push_req  = id_push & ~stall & ~exc_flush;
  assign res_req   = ex_resolve & ~stall & ~exc_flush;
  assign pop       = res_req & ~empty;
  assign res_empty = res_req & empty;
  assign miss      = pop & (ex_taken ^ head.taken);
  // A pop frees a slot the same cycle. A mispredict makes any same-cycle push wrong-path.
  assign push_ok   = push_req & (~full | pop) & ~miss;
  assign ovf       = push_req & full & ~pop;

  always_comb begin
    nxt_ctr = head.ctr;
    if (ex_taken) begin
      if (head.ctr != 2'd3) nxt_ctr = head.ctr + 2'd1;
    end else begin
      if (head.ctr != 2'd0) nxt_ctr = head.ctr - 2'd1;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push_ok) q[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      mispredict <= 1'b0;
      correct_pc <= '0;
      upd_en     <= 1'b0;
      upd_idx    <= '0;
      upd_ctr    <= '0;
      underflow  <= 1'b0;
      br_count   <= '0;
      miss_count <= '0;
    end else begin
      // Retire outputs are pulses. Data is zeroed when no branch retires.
      upd_en     <= pop;
      mispredict <= miss;
      correct_pc <= pop ? head.alt_pc : '0;
      upd_idx    <= pop ? head.idx    : '0;
      upd_ctr    <= pop ? nxt_ctr     : '0;

      if (exc_flush || miss) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
      end

      if (pop)  br_count   <= br_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
      if (ovf || res_empty) underflow <= 1'b1;
    end
  end
endmodule
